encrypter_out: RTL

Downstream stage of the encryption input packer. It takes each ciphertext word from the fast-modular-exponentiation (FME) unit, which is n_len significant bits wide. It repacks the bit stream into bytes and hands them one at a time to the UART transmitter. On a flush request it zero-pads the final partial byte and sends it, so a message of arbitrary length leaves as whole bytes.

---
 rtl/encrypter_out_pkg.sv | 33 +++
 rtl/encrypter_out.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/encrypter_out_pkg.sv
// Shared constants, state encoding and n_len clamp for the encrypter output stage.
package encrypter_out_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NLEN_IN_W = 8;
    localparam int unsigned NLEN_W    = 6;
    localparam int unsigned BCNT_W    = 3;
    localparam int unsigned N_LEN_MIN = 2;
    localparam int unsigned N_LEN_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_SEND      = 3'd3,
        ST_PAD       = 3'd4
    } state_e;

    // Clamp the packer's length output into the range the shifter supports.
    function automatic logic [NLEN_W-1:0] clamp_n_len(input logic [NLEN_IN_W-1:0] raw);
        logic [NLEN_W-1:0] res;
        if (raw < NLEN_IN_W'(N_LEN_MIN)) begin
            res = NLEN_W'(N_LEN_MIN);
        end else if (raw > NLEN_IN_W'(N_LEN_MAX)) begin
            res = NLEN_W'(N_LEN_MAX);
        end else begin
            res = NLEN_W'(raw);
        end
        return res;
    endfunction

endpackage

// File: rtl/encrypter_out.sv
// Repacks n_len-bit FME ciphertext words into a continuous LSB-first byte stream for the UART.
module encrypter_out
    import encrypter_out_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NLEN_IN_W-1:0] n_len_in,
    input  logic                 fme_done,
    input  logic [DATA_W-1:0]    fme_data_out,
    output logic                 word_ready,
    input  logic                 flush,
    input  logic                 tx_ready,
    output logic                 tx_start,
    output logic [BYTE_W-1:0]    tx_data,
    output logic                 flush_done,
    output logic                 overrun
);

    state_e              state_q,      state_d;
    logic [NLEN_W-1:0]   n_len_q,      n_len_d;
    logic [BCNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [BYTE_W-1:0]   byte_buf_q,   byte_buf_d;
    logic [DATA_W-1:0]   word_buf_q,   word_buf_d;
    logic [NLEN_W-1:0]   bits_left_q,  bits_left_d;
    logic                flushing_q,   flushing_d;
    logic                word_ready_q, word_ready_d;
    logic                tx_start_q,   tx_start_d;
    logic [BYTE_W-1:0]   tx_data_q,    tx_data_d;
    logic                flush_done_q, flush_done_d;
    logic                overrun_q,    overrun_d;

    logic                flush_pend_c;
    logic                byte_full_c;

    // Register block: synchronous reset clears everything, including any partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_len_q      <= '0;
            bit_cnt_q    <= '0;
            byte_buf_q   <= '0;
            word_buf_q   <= '0;
            bits_left_q  <= '0;
            flushing_q   <= 1'b0;
            word_ready_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            flush_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_len_q      <= n_len_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_buf_q   <= byte_buf_d;
            word_buf_q   <= word_buf_d;
            bits_left_q  <= bits_left_d;
            flushing_q   <= flushing_d;
            word_ready_q <= word_ready_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            flush_done_q <= flush_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Flush pending now or earlier; current shift/pad cycle completes a byte.
    assign flush_pend_c = flushing_q | flush;
    assign byte_full_c  = (bit_cnt_q == BCNT_W'(BYTE_W - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        n_len_d      = n_len_q;
        bit_cnt_d    = bit_cnt_q;
        byte_buf_d   = byte_buf_q;
        word_buf_d   = word_buf_q;
        bits_left_d  = bits_left_q;
        flushing_d   = flushing_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        flush_done_d = 1'b0;

        // A word arriving while we cannot take it is lost; flag it until reset.
        overrun_d = overrun_q | (fme_done & (state_q != ST_WAIT_WORD));

        // A flush arriving mid-word is remembered and honoured once the word drains.
        if (flush && (state_q != ST_IDLE) && (state_q != ST_WAIT_WORD)) begin
            flushing_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                flushing_d = 1'b0;
                if (start) begin
                    n_len_d    = clamp_n_len(n_len_in);
                    bit_cnt_d  = '0;
                    byte_buf_d = '0;
                    state_d    = ST_WAIT_WORD;
                end
            end

            ST_WAIT_WORD: begin
                if (fme_done) begin
                    word_buf_d  = fme_data_out;
                    bits_left_d = n_len_q;
                    if (flush) begin
                        flushing_d = 1'b1;
                    end
                    state_d = ST_SHIFT;
                end else if (flush) begin
                    if (bit_cnt_q != '0) begin
                        flushing_d = 1'b1;
                        state_d    = ST_PAD;
                    end else begin
                        flush_done_d = 1'b1;
                        flushing_d   = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end

            ST_SHIFT: begin
                byte_buf_d  = {word_buf_q[0], byte_buf_q[BYTE_W-1:1]};
                word_buf_d  = word_buf_q >> 1;
                bits_left_d = bits_left_q - NLEN_W'(1);
                bit_cnt_d   = bit_cnt_q + BCNT_W'(1);
                if (byte_full_c) begin
                    state_d = ST_SEND;
                end else if (bits_left_q == NLEN_W'(1)) begin
                    state_d = flush_pend_c ? ST_PAD : ST_WAIT_WORD;
                end
            end

            ST_SEND: begin
                if (tx_ready) begin
                    tx_data_d  = byte_buf_q;
                    tx_start_d = 1'b1;
                    bit_cnt_d  = '0;
                    if (bits_left_q != '0) begin
                        state_d = ST_SHIFT;
                    end else if (flush_pend_c) begin
                        // Byte boundary reached with a flush pending: nothing left to pad.
                        flush_done_d = 1'b1;
                        flushing_d   = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_WORD;
                    end
                end
            end

            ST_PAD: begin
                byte_buf_d = {1'b0, byte_buf_q[BYTE_W-1:1]};
                bit_cnt_d  = bit_cnt_q + BCNT_W'(1);
                if (byte_full_c) begin
                    state_d = ST_SEND;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        word_ready_d = (state_d == ST_WAIT_WORD);
    end

    assign word_ready = word_ready_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign flush_done = flush_done_q;
    assign overrun    = overrun_q;

endmodule
